// File: rtl/div_pkg.sv
// Shared types and helpers for the restoring divider.
// Latency/backpressure: none (types and pure functions only).
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  localparam int unsigned DIV_MAX_W = 64;

  // All-ones quotient for a w-bit divide by zero, right-aligned in a 64-bit word.
  function automatic logic [DIV_MAX_W-1:0] dbz_quotient(input int unsigned w);
    return {DIV_MAX_W{1'b1}} >> (DIV_MAX_W - w);
  endfunction

  // Two's-complement magnitude; callers zero-extend and truncate back to their width.
  function automatic logic [DIV_MAX_W-1:0] abs_val(input logic [DIV_MAX_W-1:0] v,
                                                   input logic                 neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate; purely combinational, no backpressure.
// Only present in builds with SEQ_DIVIDER_SIGNED_EN defined.
`ifdef SEQ_DIVIDER_SIGNED_EN
module div_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  assign val_o = neg_i ? (~val_i + ONE) : val_i;

endmodule
`endif

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle; WIDTH+2 cycles (2 on divide-by-zero).
// start is only taken in IDLE and ignored while busy; SEQ_DIVIDER_SIGNED_EN enables signed mode.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o,
  output logic             overflow_o
);

  localparam int unsigned      CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIDTH-1:0] DBZ_Q = WIDTH'(dbz_quotient(WIDTH));

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // dvd_q shifts the dividend out of the top while quotient bits enter at the bottom.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_out_q, quo_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dbz_out_q, dbz_out_d;
  logic             ovf_out_q, ovf_out_d;

  logic             accept;
  logic             dvs_nz;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             ovf_res;
  logic [WIDTH:0]   part;
  logic             part_ge;

  assign accept  = (state_q == IDLE) & start_i;
  assign dvs_nz  = |divisor_i;
  assign part    = {rem_q, dvd_q[WIDTH-1]};
  assign part_ge = (part >= {1'b0, dvs_q});

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic dvd_sgn, dvs_sgn;
  logic q_neg_q, q_neg_d;
  logic r_neg_q, r_neg_d;
  logic ovf_q, ovf_d;

  assign dvd_sgn = is_signed_i & dividend_i[WIDTH-1];
  assign dvs_sgn = is_signed_i & divisor_i[WIDTH-1];
  assign dvd_mag = WIDTH'(abs_val(64'(dividend_i), dvd_sgn));
  assign dvs_mag = WIDTH'(abs_val(64'(divisor_i), dvs_sgn));

  // A zero-divide leaves the raw dividend in rem_q, so both negates stay off.
  assign q_neg_d = accept ? (dvs_nz & (dvd_sgn ^ dvs_sgn)) : q_neg_q;
  assign r_neg_d = accept ? (dvs_nz & dvd_sgn) : r_neg_q;
  assign ovf_d   = accept ? (is_signed_i & (dividend_i == SMIN) & (&divisor_i)) : ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      ovf_q   <= ovf_d;
    end
  end

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
    .val_i (dvd_q),
    .neg_i (q_neg_q),
    .val_o (q_fix)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
    .val_i (rem_q),
    .neg_i (r_neg_q),
    .val_o (r_fix)
  );

  assign ovf_res = ovf_q;
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed_i;
  assign dvd_mag          = dividend_i;
  assign dvs_mag          = divisor_i;
  assign q_fix            = dvd_q;
  assign r_fix            = rem_q;
  assign ovf_res          = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dbz_out_d = dbz_out_q;
    ovf_out_d = ovf_out_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          busy_d    = 1'b1;
          cnt_d     = '0;
          dbz_out_d = 1'b0;
          ovf_out_d = 1'b0;
          if (dvs_nz) begin
            state_d = CALC;
            dvd_d   = dvd_mag;
            dvs_d   = dvs_mag;
            rem_d   = '0;
            dbz_d   = 1'b0;
          end else begin
            state_d = FIX;
            dvd_d   = DBZ_Q;
            rem_d   = dividend_i;
            dbz_d   = 1'b1;
          end
        end
      end

      CALC: begin
        dvd_d = {dvd_q[WIDTH-2:0], part_ge};
        rem_d = part_ge ? WIDTH'(part - {1'b0, dvs_q}) : part[WIDTH-1:0];
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      FIX: begin
        quo_out_d = q_fix;
        rem_out_d = r_fix;
        dbz_out_d = dbz_q;
        ovf_out_d = ovf_res;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_out_q <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dbz_out_q <= dbz_out_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign quotient_o    = quo_out_q;
  assign remainder_o   = rem_out_q;
  assign div_by_zero_o = dbz_out_q;
  assign overflow_o    = ovf_out_q;

endmodule
